// File: rtl/dma_if.sv
// DMA handshake bundle between the controller, the CPU (BR/BG/DMA_end) and the
// device line buffer (dev_line_idx/dev_line).
interface dma_if;
  logic        DMA_begin;
  logic [15:0] DMA_command;
  logic        BR;
  logic        BG;
  logic        DMA_end;
  logic [1:0]  dev_line_idx;
  logic [63:0] dev_line;

  modport master (
    input  DMA_begin, DMA_command, BG, dev_line,
    output BR, DMA_end, dev_line_idx
  );

  modport slave (
    output DMA_begin, DMA_command, BG, dev_line,
    input  BR, DMA_end, dev_line_idx
  );
endinterface

// File: rtl/dma_controller.sv
// Device-to-memory DMA engine: fetches 64-bit device lines and writes them to data
// memory under a BR/BG bus handshake. Define DMA_CYCLE_STEAL_EN for cycle-steal mode.
module dma_controller #(
  parameter int MEM_WR_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  dma_if.master       bus,
  output wire         d_writeM,
  output wire  [15:0] d_address,
  output wire  [63:0] d_data
);

  localparam int CW = (MEM_WR_CYCLES > 1) ? $clog2(MEM_WR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, REQ, WRITE, GAP, DONE} state_e;

  state_e        state_q;
  logic          begin_q;
  logic [11:0]   base_q;
  logic [2:0]    lines_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          br_q;
  logic          end_q;
  logic          wr_q;
  logic [63:0]   data_q;

  logic [3:0]  cmd_len;
  logic [2:0]  cmd_lines;
  logic        last_line;
  logic [15:0] line_addr;
  logic [63:0] line_data;

  assign cmd_len   = bus.DMA_command[15:12];
  assign cmd_lines = {1'b0, cmd_len[3:2]} + {2'b00, |cmd_len[1:0]};
  assign last_line = ({1'b0, idx_q} == lines_q - 3'd1);
  assign line_addr = {4'h0, base_q} + {12'h000, idx_q, 2'b00};
  // The first cycle of a line presents the live device word, so a back-to-back
  // burst line needs no extra fetch cycle after idx advances.
  assign line_data = (cnt_q == '0) ? bus.dev_line : data_q;

  assign bus.BR           = br_q;
  assign bus.DMA_end      = end_q;
  assign bus.dev_line_idx = idx_q;

  assign d_writeM  = bus.BG ? wr_q      : 1'bz;
  assign d_address = bus.BG ? line_addr : 16'hzzzz;
  assign d_data    = bus.BG ? line_data : {64{1'bz}};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      begin_q <= 1'b0;
      base_q  <= '0;
      lines_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      end_q   <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: defaults use <= too; a later <= in the case wins, and every
      // register stays a flop with no ordering hazards between blocks.
      begin_q <= bus.DMA_begin;
      end_q   <= 1'b0;
      case (state_q)
        IDLE: if (bus.DMA_begin && !begin_q) state_q <= CMD;
        CMD: begin
          base_q  <= bus.DMA_command[11:0];
          lines_q <= cmd_lines;
          idx_q   <= '0;
          cnt_q   <= '0;
          if (cmd_len == 4'd0) begin
            state_q <= DONE;
            end_q   <= 1'b1;
          end else begin
            state_q <= REQ;
            br_q    <= 1'b1;
          end
        end
        REQ: if (bus.BG) begin
          state_q <= WRITE;
          wr_q    <= 1'b1;
          cnt_q   <= '0;
        end
        WRITE: begin
          if (!bus.BG) begin
            // Grant lost: restart this same line from its first cycle later.
            state_q <= REQ;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            data_q <= line_data;
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (last_line) begin
                state_q <= DONE;
                wr_q    <= 1'b0;
                br_q    <= 1'b0;
                end_q   <= 1'b1;
              end else begin
                idx_q <= idx_q + 2'd1;
`ifdef DMA_CYCLE_STEAL_EN
                state_q <= GAP;
                wr_q    <= 1'b0;
                br_q    <= 1'b0;
`else
                state_q <= WRITE;
`endif
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        GAP: begin
          state_q <= REQ;
          br_q    <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: burst, zero length, partial line, grant loss
// and reset abort, with a simple CPU grant model and a bus write monitor.
module tb_dma_controller;
  localparam int N = 4;
`ifdef DMA_CYCLE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  wire         d_writeM;
  wire  [15:0] d_address;
  wire  [63:0] d_data;

  dma_if bus();

  dma_controller #(.MEM_WR_CYCLES(N)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .d_writeM (d_writeM),
    .d_address(d_address),
    .d_data   (d_data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] line_of(input logic [1:0] i);
    return {16'hCAFE, 30'h0, i, 16'h5A5A};
  endfunction

  assign bus.dev_line = line_of(bus.dev_line_idx);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus monitor: sampled on the falling edge, splits write runs on address change.
  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          len;
  } seg_t;

  seg_t segs[$];
  seg_t cur;
  int   cyc = 0, end_cnt = 0, end_cyc = 0, last_wr_cyc = 0, br_rise = 0, br_hi = 0;
  logic br_last = 1'b0;
  logic bg_drop = 1'b0;

  always @(negedge Clk) begin
    cyc++;
    if (d_writeM === 1'b1) begin
      if (cur.len > 0 && d_address !== cur.addr) begin
        segs.push_back(cur);
        cur.len = 0;
      end
      if (cur.len == 0) begin
        cur.addr = d_address;
        cur.data = d_data;
      end
      cur.len++;
      last_wr_cyc = cyc;
    end else if (cur.len > 0) begin
      segs.push_back(cur);
      cur.len = 0;
    end
    if (bus.DMA_end === 1'b1) begin
      end_cnt++;
      end_cyc = cyc;
    end
    if (bus.BR === 1'b1) begin
      br_hi++;
      if (!br_last) br_rise++;
    end
    br_last = (bus.BR === 1'b1);
  end

  // CPU grants one cycle after it sees BR, and releases when BR drops.
  always @(posedge Clk) begin
    #2;
    bus.BG = br_last && !bg_drop;
  end

  int run_cyc, b_seg, b_end, b_rise, b_hi;

  task automatic step();
    @(posedge Clk);
    #1;
    run_cyc++;
  endtask

  task automatic start_cmd(input logic [15:0] cmd);
    b_seg  = segs.size();
    b_end  = end_cnt;
    b_rise = br_rise;
    b_hi   = br_hi;
    bus.DMA_command = cmd;
    bus.DMA_begin   = 1'b1;
    run_cyc = 0;
    step();
    bus.DMA_begin = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    while (bus.DMA_end !== 1'b1 && run_cyc < budget) step();
    if (bus.DMA_end !== 1'b1) check({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic check_seg(input string tag, input int k, input logic [15:0] addr,
                           input logic [63:0] data, input int len);
    if (b_seg + k < segs.size()) begin
      check({tag, "_addr"}, segs[b_seg + k].addr, addr);
      check({tag, "_data"}, segs[b_seg + k].data, data);
      check({tag, "_len"}, segs[b_seg + k].len, len);
    end else begin
      check({tag, "_missing"}, segs.size(), b_seg + k + 1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.DMA_begin   = 1'b0;
    bus.DMA_command = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_br", bus.BR, 0);
    check("rst_end", bus.DMA_end, 0);
    check("rst_idx", bus.dev_line_idx, 0);
    check("rst_wr", d_writeM === 1'b1, 0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Three full lines from 0x01F4
    start_cmd(16'hC1F4);
    wait_end("burst", 60);
    check("burst_lat", run_cyc, STEAL ? 22 : 16);
    check("burst_ends", end_cnt - b_end, 1);
    check("burst_br_rise", br_rise - b_rise, STEAL ? 3 : 1);
    check("burst_br_hi", br_hi - b_hi, STEAL ? 18 : 14);
    check("burst_end_gap", end_cyc - last_wr_cyc, 1);
    check("burst_nseg", segs.size() - b_seg, 3);
    check_seg("burst0", 0, 16'h01F4, line_of(2'd0), N);
    check_seg("burst1", 1, 16'h01F8, line_of(2'd1), N);
    check_seg("burst2", 2, 16'h01FC, line_of(2'd2), N);

    // Zero length: no bus request, DMA_end two edges after DMA_begin
    start_cmd(16'h0100);
    wait_end("len0", 20);
    check("len0_lat", run_cyc, 2);
    check("len0_br_rise", br_rise - b_rise, 0);
    check("len0_ends", end_cnt - b_end, 1);
    check("len0_nseg", segs.size() - b_seg, 0);

    // Five words: partial second line crossing 0x1000
    start_cmd(16'h5FFE);
    wait_end("part", 40);
    check("part_lat", run_cyc, STEAL ? 15 : 12);
    check("part_nseg", segs.size() - b_seg, 2);
    check_seg("part0", 0, 16'h0FFE, line_of(2'd0), N);
    check_seg("part1", 1, 16'h1002, line_of(2'd1), N);

    // Grant withdrawn in the second write cycle of the first line
    start_cmd(16'hC1F4);
    while (d_writeM !== 1'b1 && run_cyc < 20) step();
    check("gl_started", d_writeM === 1'b1, 1);
    step();
    bg_drop = 1'b1;
    #3;
    check("gl_wr_released", d_writeM === 1'b1, 0);
    step();
    check("gl_br_hold", bus.BR, 1);
    repeat (2) step();
    bg_drop = 1'b0;
    wait_end("gl", 80);
    check("gl_ends", end_cnt - b_end, 1);
    check("gl_nseg", segs.size() - b_seg, 4);
    check_seg("gl0", 0, 16'h01F4, line_of(2'd0), 1);
    check_seg("gl1", 1, 16'h01F4, line_of(2'd0), N);
    check_seg("gl2", 2, 16'h01F8, line_of(2'd1), N);
    check_seg("gl3", 3, 16'h01FC, line_of(2'd2), N);

    // Reset during the second line aborts silently
    start_cmd(16'hC1F4);
    while (!(d_writeM === 1'b1 && d_address === 16'h01F8) && run_cyc < 60) step();
    check("ra_line2", d_address, 16'h01F8);
    Reset = 1'b1;
    #1;
    check("ra_br", bus.BR, 0);
    check("ra_end", bus.DMA_end, 0);
    check("ra_idx", bus.dev_line_idx, 0);
    b_end = end_cnt;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("ra_no_end", end_cnt - b_end, 0);
    check("ra_br_idle", bus.BR, 0);

    start_cmd(16'h8040);
    wait_end("ra_rerun", 40);
    check("ra_rerun_lat", run_cyc, STEAL ? 15 : 12);
    check("ra_rerun_ends", end_cnt - b_end, 1);
    check("ra_rerun_nseg", segs.size() - b_seg, 2);
    check_seg("ra_rerun0", 0, 16'h0040, line_of(2'd0), N);
    check_seg("ra_rerun1", 1, 16'h0044, line_of(2'd1), N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
